// File: rtl/fpu_pkg.sv
// Shared types for the compare-unit arbiter: opcode encoding and controller states.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_EQ = 3'd0,
        OP_NE = 3'd1,
        OP_LE = 3'd2,
        OP_GE = 3'd3,
        OP_LT = 3'd4,
        OP_GT = 3'd5
    } cmp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } arb_state_t;

    // Encodings 6 and 7 have no compare meaning and are bounced at accept.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_GT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requesting index at or after ptr wins, wrapping to index 0.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    // Requests at or above ptr take priority; fall back to the full vector on wrap.
    always_comb begin
        hi_mask = ~((N'(1) << ptr) - N'(1));
        masked  = req & hi_mask;
        pick    = (|masked) ? masked : req;
        grant   = pick & (~pick + N'(1));
    end

endmodule

// File: rtl/fpu_cmp_arb.sv
// Arbitrates N_REQ requesters onto one shared FP compare unit, with timeout and
// illegal-opcode rejection; the response is routed back to the owning requester.
module fpu_cmp_arb
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    input  logic [N_REQ-1:0][2:0]  req_op,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   fu_valid,
    output logic [31:0]            fu_a,
    output logic [31:0]            fu_b,
    output logic [2:0]             fu_op,
    input  logic [31:0]            fu_c_data,
    input  logic                   fu_done
);

    localparam int PW = (N_REQ > 2) ? 2 : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    logic [PW-1:0]    rr_ptr, owner, acc_id;
    logic [N_REQ-1:0] grant;
    logic [CW-1:0]    cnt;
    logic [31:0]      a_q, b_q;
    logic [2:0]       op_q;
    logic             acc, acc_legal, tmo;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        req_ready = (state == ST_IDLE) ? grant : '0;
        acc       = |req_ready;
        acc_id    = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) acc_id = PW'(i);
        acc_legal = op_legal(req_op[acc_id]);
        tmo       = (cnt == CW'(TIMEOUT - 1));
        fu_valid  = (state == ST_BUSY) && !fu_done;
        fu_a      = a_q;
        fu_b      = b_q;
        fu_op     = op_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (acc && acc_legal) state_nxt = ST_BUSY;
            ST_BUSY:  if (fu_done || tmo)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (!fu_done)         state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: if (acc) begin
                    rr_ptr <= (acc_id == PW'(N_REQ - 1)) ? '0 : acc_id + PW'(1);
                    owner  <= acc_id;
                    cnt    <= '0;
                    if (acc_legal) begin
                        a_q  <= req_a[acc_id];
                        b_q  <= req_b[acc_id];
                        op_q <= req_op[acc_id];
                    end else begin
                        rsp_valid[acc_id] <= 1'b1;
                        rsp_data          <= '0;
                        rsp_err           <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (fu_done) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_data         <= fu_c_data;
                        rsp_err          <= 1'b0;
                    end else if (tmo) begin
                        // Unit never answered: report the error and abandon it.
                        rsp_valid[owner] <= 1'b1;
                        rsp_data         <= '0;
                        rsp_err          <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cmp_arb.sv
// Randomized self-checking bench for fpu_cmp_arb with a behavioural 2-cycle compare unit.
module tb_fpu_cmp_arb;
    import fpu_pkg::*;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [1:0]       req_valid, req_ready, rsp_valid;
    logic [1:0][31:0] req_a, req_b;
    logic [1:0][2:0]  req_op;
    logic [31:0]      rsp_data, fu_a, fu_b, fu_c_data;
    logic             rsp_err, fu_valid, fu_done;
    logic [2:0]       fu_op;

    int errors = 0;
    int checks = 0;
    int mptr   = 0;
    int fu_cnt = 0;
    logic fu_en = 1'b1;

    fpu_cmp_arb #(.N_REQ(2), .TIMEOUT(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_c_data(fu_c_data), .fu_done(fu_done)
    );

    always #5 aclk = ~aclk;

    // IEEE-754 single compare: NaN unordered, +0 == -0.
    function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint ka, kb;
        logic nan;
        nan = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0);
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        if (nan) return op == 3'(OP_NE);
        case (op)
            3'd0: return ka == kb;
            3'd1: return ka != kb;
            3'd2: return ka <= kb;
            3'd3: return ka >= kb;
            3'd4: return ka <  kb;
            3'd5: return ka >  kb;
            default: return 1'b0;
        endcase
    endfunction

    // Compare unit answers two cycles after it first sees fu_valid.
    always @(posedge aclk) fu_cnt <= fu_valid ? fu_cnt + 1 : 0;
    assign fu_done   = fu_en && (fu_cnt == 2);
    assign fu_c_data = {31'b0, ref_cmp(fu_a, fu_b, fu_op)};

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] tbl [8];
        tbl = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                32'h4000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'hC040_0000};
        if ($urandom_range(0, 1) == 0) return $urandom();
        return tbl[$urandom_range(0, 7)];
    endfunction

    task automatic rand_req(input int i);
        req_a[i]  = pick_val();
        req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : pick_val();
        req_op[i] = 3'($urandom_range(0, 5));
    endtask

    // Issue one request and wait (bounded) for its response; lat counts the accept cycle as 1.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output logic rdy, output int lat, output int fv,
                          output logic [1:0] v, output logic [31:0] d, output logic e);
        req_a[id] = a; req_b[id] = b; req_op[id] = op;
        req_valid = '0;
        req_valid[id] = 1'b1;
        #1;
        rdy = req_ready[id];
        if (rdy) mptr = (id + 1) % 2;
        tick();
        req_valid = '0;
        lat = 1;
        fv  = 0;
        while (rsp_valid == 2'b00 && lat < 40) begin
            if (fu_valid === 1'b1) fv++;
            tick();
            lat++;
        end
        if (rsp_valid == 2'b00) lat = -1;
        v = rsp_valid; d = rsp_data; e = rsp_err;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        tick(); tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_data, rsp_err); end
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL reset_fu_valid got %b want 0", fu_valid); end
        checks++; if (fu_a !== 32'h0 || fu_b !== 32'h0 || fu_op !== 3'h0) begin errors++; $display("FAIL reset_operands got %h %h %h want 0", fu_a, fu_b, fu_op); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_idle got %b want 00", req_ready); end
        aresetn = 1'b1;
        mptr = 0;
    endtask

    task automatic test_single();
        int lat;
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h4000_0000; req_op[0] = OP_LT;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        tick();
        req_valid = '0;
        mptr = 1;
        checks++;
        if (fu_valid !== 1'b1 || fu_a !== 32'h3F80_0000 || fu_b !== 32'h4000_0000 || fu_op !== 3'(OP_LT)) begin
            errors++; $display("FAIL single_fu_drive got v=%b a=%h b=%h op=%0d want 1 3f800000 40000000 4", fu_valid, fu_a, fu_b, fu_op);
        end
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 40) begin tick(); lat++; end
        checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v=%b d=%h e=%b want 01 00000001 0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
        checks++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h1) begin
            errors++; $display("FAIL single_hold got v=%b d=%h want 00 00000001", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_contention();
        int   q_own[$];
        logic q_dat[$];
        int   grants = 0, rsps = 0, cyc = 0, acc_w, w, own;
        logic dexp;
        rand_req(0); rand_req(1);
        req_valid = 2'b11;
        while ((grants < 8 || rsps < grants) && cyc < 300) begin
            if (grants >= 8) req_valid = '0;
            #1;
            if (rsp_valid != 2'b00) begin
                checks++;
                if (q_own.size() == 0) begin
                    errors++; $display("FAIL contention_spurious_rsp got %b want 00", rsp_valid);
                end else begin
                    own  = q_own.pop_front();
                    dexp = q_dat.pop_front();
                    if (rsp_valid !== 2'(1 << own) || rsp_data !== {31'b0, dexp} || rsp_err !== 1'b0)
                        begin errors++; $display("FAIL contention_rsp got v=%b d=%h e=%b want v=%b d=%h e=0", rsp_valid, rsp_data, rsp_err, 2'(1 << own), {31'b0, dexp}); end
                end
                rsps++;
            end
            acc_w = -1;
            if (req_ready != 2'b00) begin
                w = -1;
                for (int k = 0; k < 2; k++)
                    if (w < 0 && req_valid[(mptr + k) % 2]) w = (mptr + k) % 2;
                checks++;
                if (w < 0 || req_ready !== 2'(1 << w)) begin
                    errors++; $display("FAIL contention_grant got %b want winner %0d", req_ready, w);
                end
                if (w >= 0) begin
                    q_own.push_back(w);
                    q_dat.push_back(ref_cmp(req_a[w], req_b[w], req_op[w]));
                    mptr  = (w + 1) % 2;
                    acc_w = w;
                end
                grants++;
            end
            tick();
            cyc++;
            if (acc_w >= 0) rand_req(acc_w);
        end
        req_valid = '0;
        checks++;
        if (grants < 8 || rsps < grants) begin
            errors++; $display("FAIL contention_progress got grants=%0d rsps=%0d want 8/8", grants, rsps);
        end
    endtask

    task automatic test_signed_zero();
        logic rdy, e; int lat, fv; logic [1:0] v; logic [31:0] d;
        tick();
        run_op(0, 32'h8000_0000, 32'h0000_0000, OP_EQ, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || v !== 2'b01 || d !== 32'h1 || e !== 1'b0) begin
            errors++; $display("FAIL signed_zero_eq got rdy=%b v=%b d=%h e=%b want 1 01 00000001 0", rdy, v, d, e);
        end
        tick();
        run_op(1, 32'h0000_0000, 32'h8000_0000, OP_LT, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || v !== 2'b10 || d !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL signed_zero_lt got rdy=%b v=%b d=%h e=%b want 1 10 00000000 0", rdy, v, d, e);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic rdy, e; int lat, fv, seen; logic [1:0] v; logic [31:0] d;
        // Leave a nonzero rsp_data behind so the zeroing is visible.
        run_op(0, 32'h3F80_0000, 32'h3F80_0000, OP_GE, rdy, lat, fv, v, d, e);
        tick();
        run_op(1, 32'h3F80_0000, 32'h4000_0000, 3'd7, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 1) begin errors++; $display("FAIL illegal7_latency got rdy=%b lat=%0d want 1 1", rdy, lat); end
        checks++; if (v !== 2'b10 || d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL illegal7_rsp got v=%b d=%h e=%b want 10 00000000 1", v, d, e);
        end
        seen = fu_valid;
        for (int i = 0; i < 4; i++) begin tick(); if (fu_valid === 1'b1) seen = 1; end
        checks++; if (seen != 0 || fv != 0) begin errors++; $display("FAIL illegal7_fu_valid got asserted want never"); end
        run_op(0, 32'h0, 32'h0, 3'd6, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 1 || v !== 2'b01 || e !== 1'b1 || fv != 0) begin
            errors++; $display("FAIL illegal6_rsp got rdy=%b lat=%0d v=%b e=%b fv=%0d want 1 1 01 1 0", rdy, lat, v, e, fv);
        end
        run_op(1, 32'h4000_0000, 32'h3F80_0000, OP_GT, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 4 || v !== 2'b10 || d !== 32'h1 || e !== 1'b0) begin
            errors++; $display("FAIL illegal_then_legal got rdy=%b lat=%0d v=%b d=%h e=%b want 1 4 10 00000001 0", rdy, lat, v, d, e);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic rdy, e; int lat, fv; logic [1:0] v; logic [31:0] d;
        fu_en = 1'b0;
        run_op(0, 32'h4000_0000, 32'h3F80_0000, OP_GT, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 17 || fv != 16) begin
            errors++; $display("FAIL timeout_cycles got rdy=%b lat=%0d busy=%0d want 1 17 16", rdy, lat, fv);
        end
        checks++; if (v !== 2'b01 || d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL timeout_rsp got v=%b d=%h e=%b want 01 00000000 1", v, d, e);
        end
        fu_en = 1'b1;
        tick();
        run_op(1, 32'hBF80_0000, 32'h3F80_0000, OP_LE, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 4 || v !== 2'b10 || d !== 32'h1 || e !== 1'b0) begin
            errors++; $display("FAIL timeout_recover got rdy=%b lat=%0d v=%b d=%h e=%b want 1 4 10 00000001 0", rdy, lat, v, d, e);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        logic rdy, e; int lat, fv; logic [1:0] v; logic [31:0] d;
        req_a[1] = 32'h3F80_0000; req_b[1] = 32'h3F80_0000; req_op[1] = OP_EQ;
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        tick();
        aresetn = 1'b0;
        tick();
        checks++; if (fu_valid !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_busy_abort got fu_valid=%b rsp_valid=%b want 0 00", fu_valid, rsp_valid);
        end
        aresetn = 1'b1;
        mptr = 0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_busy_ptr got %b want 01", req_ready); end
        req_valid = '0;
        run_op(0, 32'hC040_0000, 32'h3F80_0000, OP_NE, rdy, lat, fv, v, d, e);
        checks++; if (!rdy || lat != 4 || v !== 2'b01 || d !== 32'h1 || e !== 1'b0) begin
            errors++; $display("FAIL reset_busy_after got rdy=%b lat=%0d v=%b d=%h e=%b want 1 4 01 00000001 0", rdy, lat, v, d, e);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_signed_zero();
        test_illegal();
        test_timeout();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
